mealy_seq_det: RTL

- Parametrised Mealy serial pattern detector. It replaces the fixed 4-state Mealy controllers in the serial front end.
- One data bit is consumed per enabled clock. The match output asserts combinationally in the same cycle the last pattern bit is present on data_in.
- Pattern is run-time loadable, pattern width is parametrised, and overlapping or non-overlapping detection is selectable.
- A registered copy of the match output and a saturating match counter feed downstream status logic.

---
 rtl/mealy_seq_det_pkg.sv | 21 ++
 rtl/mealy_seq_det_sat_cnt.sv | 26 ++
 rtl/mealy_seq_det.sv | 96 +++++++++
 3 files changed

// File: rtl/mealy_seq_det_pkg.sv
// Shared types and helpers for the parametrised Mealy pattern detector.
package mealy_seq_det_pkg;

    typedef enum logic {
        S_FILL = 1'b0,
        S_HUNT = 1'b1
    } state_t;

    localparam int PAT_W_MAX = 16;

    // Smallest width able to count 0..n-1, never narrower than one bit.
    function automatic int fill_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 6; i++) begin
            if ((1 << w) < n) w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/mealy_seq_det_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module mealy_seq_det_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/mealy_seq_det.sv
// Parametrised Mealy serial pattern detector with run-time loadable pattern.
// Build option MEALY_SEQ_DET_CNT_EN enables the saturating match counter.
module mealy_seq_det
    import mealy_seq_det_pkg::*;
#(
    parameter int                 PAT_W   = 4,
    parameter int                 CNT_W   = 8,
    parameter logic [PAT_W-1:0]   RST_PAT = PAT_W'(4'b1011)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             data_in,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             overlap,
    output logic             match,
    output logic             match_q,
    output logic             hunting,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int               FILL_W    = fill_width(PAT_W);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 2);

    if (PAT_W < 2 || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
        $error("mealy_seq_det: PAT_W out of range");
    end

    logic [PAT_W-1:0]  r_pat;
    logic [PAT_W-2:0]  r_hist;
    logic [FILL_W-1:0] r_fill;
    state_t            r_state;
    logic              r_match_q;

    logic [PAT_W-1:0]  w_window;
    logic              w_match;

    // en is a bit-valid strobe with no back-pressure: every cycle with en=1 and
    // pat_load=0 consumes exactly one data_in bit; pat_load overrides both.
    assign w_window = {r_hist, data_in};
    assign w_match  = en & (r_state == S_HUNT) & ~pat_load & (w_window == r_pat);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pat     <= RST_PAT;
            r_hist    <= '0;
            r_fill    <= '0;
            r_state   <= S_FILL;
            r_match_q <= 1'b0;
        end else begin
            r_match_q <= w_match;
            if (pat_load) begin
                r_pat   <= pat_in;
                r_hist  <= '0;
                r_fill  <= '0;
                r_state <= S_FILL;
            end else if (en) begin
                r_hist <= w_window[PAT_W-2:0];
                case (r_state)
                    S_FILL: begin
                        r_fill <= r_fill + FILL_W'(1);
                        if (r_fill == FILL_LAST) r_state <= S_HUNT;
                    end
                    S_HUNT: begin
                        // Non-overlapping mode demands a completely fresh pattern.
                        if (w_match && !overlap) begin
                            r_fill  <= '0;
                            r_state <= S_FILL;
                        end
                    end
                    default: r_state <= S_FILL;
                endcase
            end
        end
    end

    assign match   = w_match;
    assign match_q = r_match_q;
    assign hunting = (r_state == S_HUNT);

`ifdef MEALY_SEQ_DET_CNT_EN
    mealy_seq_det_sat_cnt #(
        .CNT_W(CNT_W)
    ) u_sat_cnt (
        .i_clk  (clk),
        .i_reset(reset),
        .i_clr  (pat_load),
        .i_inc  (w_match),
        .o_cnt  (match_cnt)
    );
`else
    assign match_cnt = '0;
`endif

endmodule
